// File: rtl/vscale_dmem_responder_if.sv
// Handshake bundle between the vscale pipeline's dmem port and the data
// memory responder. The core drives the request side; the responder drives
// wait, read data and the access-error flag.
interface vscale_dmem_responder_if;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic        dmem_wait;
    logic [31:0] dmem_rdata;
    logic        dmem_badmem_e;

    modport master (
        output dmem_en,
        output dmem_wen,
        output dmem_size,
        output dmem_addr,
        output dmem_wdata_delayed,
        input  dmem_wait,
        input  dmem_rdata,
        input  dmem_badmem_e
    );

    modport slave (
        input  dmem_en,
        input  dmem_wen,
        input  dmem_size,
        input  dmem_addr,
        input  dmem_wdata_delayed,
        output dmem_wait,
        output dmem_rdata,
        output dmem_badmem_e
    );
endinterface

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale dmem port. Requests are pipelined:
// an address phase is latched on an accepting edge, then a data phase of
// WAIT_CYCLES wait states followed by one final (LAST) cycle in which load
// data and the error flag are presented and store data is committed.
// Storage is four byte-lane RAMs so byte/half/word stores map onto lane
// write enables. All outputs decode registered state only.
module vscale_dmem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vscale_dmem_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             count_reg, count_next;
    logic [ADDR_BITS-1:0]   word_reg;
    logic [1:0]             offset_reg;
    logic                   wen_reg;
    logic [2:0]             size_reg;
    logic                   bad_reg;

    logic                   accept;
    logic                   req_bad;
    logic [ADDR_BITS-1:0]   req_word;
    logic                   commit;
    logic [3:0]             commit_lanes;
    logic                   same_word;
    logic [31:0]            rdata_word;

    // Lanes touched by an access of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
        case (size)
            3'd0:    lane_mask = 4'b0001 << offset;
            3'd1:    lane_mask = offset[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // A new address phase is taken whenever the core is not being stalled.
    assign accept   = bus.dmem_en && (state_reg != ST_WAIT);
    assign req_word = bus.dmem_addr[ADDR_BITS+1:2];
    assign req_bad  = ((bus.dmem_addr >> (ADDR_BITS + 2)) != 32'd0)
                   || (bus.dmem_size > 3'd2)
                   || ((bus.dmem_size == 3'd1) && bus.dmem_addr[0])
                   || ((bus.dmem_size == 3'd2) && (bus.dmem_addr[1:0] != 2'b00));

    // Stores land at the end of LAST; a reset on that edge discards them.
    assign commit       = reset_n && (state_reg == ST_LAST) && wen_reg && !bad_reg;
    assign commit_lanes = lane_mask(size_reg, offset_reg);
    assign same_word    = (req_word == word_reg);

    // Next-state and wait-counter logic for the data-phase sequencer.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE, ST_LAST: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_LAST;
                        count_next = 4'd0;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = WAIT_INIT;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = ST_LAST;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // Sequencer state and the latched request fields.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            count_reg  <= 4'd0;
            word_reg   <= '0;
            offset_reg <= 2'b00;
            wen_reg    <= 1'b0;
            size_reg   <= 3'd0;
            bad_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                word_reg   <= req_word;
                offset_reg <= bus.dmem_addr[1:0];
                wen_reg    <= bus.dmem_wen;
                size_reg   <= bus.dmem_size;
                bad_reg    <= req_bad;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rbyte_reg;
            logic       write_en;

            assign write_en = commit && commit_lanes[gi];

            // Byte-lane RAM: store commit write, read captured at accept with
            // forwarding of a same-edge commit to the same word.
            always_ff @(posedge clk) begin
                if (write_en) begin
                    mem[word_reg] <= bus.dmem_wdata_delayed[gi*8 +: 8];
                end
                if (accept) begin
                    if (write_en && same_word) begin
                        rbyte_reg <= bus.dmem_wdata_delayed[gi*8 +: 8];
                    end else begin
                        rbyte_reg <= mem[req_word];
                    end
                end
            end

            assign rdata_word[gi*8 +: 8] = rbyte_reg;
        end
    endgenerate

    assign bus.dmem_wait     = (state_reg == ST_WAIT);
    assign bus.dmem_rdata    = ((state_reg == ST_LAST) && !wen_reg && !bad_reg) ? rdata_word : 32'd0;
    assign bus.dmem_badmem_e = (state_reg == ST_LAST) && bad_reg;

endmodule
